// File: rtl/strobe_checker.sv
// Scoreboard-style strobe checker: queues masked expected vectors and compares them against DUT output strobes.
// Optional build macro STROBE_CHECKER_STOP_ON_FAIL_EN freezes checking (HALT state) after the first mismatch.
module strobe_checker #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     exp_valid,
    output logic                     exp_ready,
    input  logic [WIDTH-1:0]         exp_data,
    input  logic [WIDTH-1:0]         exp_mask,
    input  logic                     act_valid,
    input  logic [WIDTH-1:0]         act_data,
    output logic                     mismatch,
    output logic                     orphan,
    output logic                     err_sticky,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic [CNT_W-1:0]         first_idx,
    output logic [WIDTH-1:0]         first_exp,
    output logic [WIDTH-1:0]         first_act,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

`ifdef STROBE_CHECKER_STOP_ON_FAIL_EN
    typedef enum logic [1:0] {IDLE, ACTIVE, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACTIVE} state_t;
`endif

    state_t state, state_next;

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [WIDTH-1:0] mem_mask [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] head_data, head_mask;
    logic             full, empty, halted;
    logic             push, pop, orphan_evt, fail_bit;
    logic             captured;

`ifdef STROBE_CHECKER_STOP_ON_FAIL_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

    assign full       = (level == LW'(DEPTH));
    assign empty      = (level == '0);
    assign exp_ready  = !full && !halted;
    assign push       = exp_valid && exp_ready;
    assign pop        = act_valid && !empty && !halted;
    assign orphan_evt = act_valid && empty && !halted;
    assign head_data  = mem_data[rd_ptr];
    assign head_mask  = mem_mask[rd_ptr];
    assign fail_bit   = |((act_data ^ head_data) & head_mask);

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (push) state_next = ACTIVE;
            ACTIVE: begin
`ifdef STROBE_CHECKER_STOP_ON_FAIL_EN
                if (pop && fail_bit && !clear)
                    state_next = HALT;
                else
`endif
                if (pop && !push && level == LW'(1))
                    state_next = IDLE;
            end
`ifdef STROBE_CHECKER_STOP_ON_FAIL_EN
            HALT: if (clear) state_next = (level != '0) ? ACTIVE : IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the vector storage has no reset; the pointers and level alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[wr_ptr] <= exp_data;
            mem_mask[wr_ptr] <= exp_mask;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            mismatch   <= 1'b0;
            orphan     <= 1'b0;
            err_sticky <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            first_idx  <= '0;
            first_exp  <= '0;
            first_act  <= '0;
            captured   <= 1'b0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level    <= level + LW'(push) - LW'(pop);
            // A clear in the same cycle discards the result of any compare or orphan event.
            mismatch <= pop && fail_bit && !clear;
            orphan   <= orphan_evt && !clear;
            if (clear) begin
                err_sticky <= 1'b0;
                pass_cnt   <= '0;
                fail_cnt   <= '0;
                first_idx  <= '0;
                first_exp  <= '0;
                first_act  <= '0;
                captured   <= 1'b0;
            end else begin
                if (pop) begin
                    if (fail_bit) begin
                        err_sticky <= 1'b1;
                        if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + 1'b1;
                        if (!captured) begin
                            captured  <= 1'b1;
                            first_idx <= pass_cnt + fail_cnt;
                            first_exp <= head_data & head_mask;
                            first_act <= act_data;
                        end
                    end else if (pass_cnt != {CNT_W{1'b1}}) begin
                        pass_cnt <= pass_cnt + 1'b1;
                    end
                end
                if (orphan_evt) err_sticky <= 1'b1;
            end
        end
    end

endmodule
